// File: rtl/seq_pkg.sv
// Shared state encodings and small helpers for the 1010 serial transmitter and its matcher.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } tx_state_t;

    typedef enum logic [1:0] {
        S0   = 2'd0,
        S1   = 2'd1,
        S10  = 2'd2,
        S101 = 2'd3
    } match_state_t;

    localparam logic [7:0] MATCH_CNT_MAX = 8'd255;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == MATCH_CNT_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/pat_match_1010.sv
// Non-overlapping 1010 Mealy detector; advances only on enabled bits, clr returns it to S0.
module pat_match_1010
    import seq_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic x,
    output logic exp_z
);

    match_state_t state_q, state_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        exp_z   = 1'b0;
        if (clr) begin
            state_d = S0;
        end else if (en) begin
            unique case (state_q)
                S0:   state_d = x ? S1 : S0;
                S1:   state_d = x ? S1 : S10;
                S10:  state_d = x ? S101 : S0;
                S101: begin
                    // Completing 0 restarts from S0 so matches never overlap
                    state_d = x ? S1 : S0;
                    exp_z   = !x;
                end
                default: state_d = S0;
            endcase
        end
    end

endmodule

// File: rtl/seq_tx_1010.sv
// Frame serializer: accepts a frame in IDLE, shifts it out MSB-first, pulses done, and counts
// 1010 matches seen on its own output stream.
module seq_tx_1010
    import seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int LW    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [LW-1:0]    in_len,
    output logic             x,
    output logic             x_valid,
    output logic             done,
    output logic             exp_z,
    output logic [7:0]       match_cnt
);

    localparam logic [LW-1:0] WIDTH_L = LW'(WIDTH);
    localparam logic [LW-1:0] CNT_ONE = LW'(1);

    tx_state_t        state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [LW-1:0]    cnt_q, cnt_d;
    logic [7:0]       match_cnt_q, match_cnt_d;
    logic [LW-1:0]    len_clamped;
    logic             accept;

    assign len_clamped = (in_len > WIDTH_L) ? WIDTH_L : in_len;
    assign in_ready    = (state_q == IDLE);
    assign accept      = in_ready && in_valid;
    assign x_valid     = (state_q == SHIFT);
    assign x           = x_valid && shreg_q[WIDTH-1];
    assign done        = (state_q == DONE);
    assign match_cnt   = match_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            match_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            match_cnt_q <= match_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    shreg_d = in_data;
                    cnt_d   = len_clamped;
                    state_d = (len_clamped == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                cnt_d   = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Count is cleared on accept and otherwise holds across the idle gap between frames
    always_comb begin
        match_cnt_d = match_cnt_q;
        if (accept) begin
            match_cnt_d = '0;
        end else if (exp_z) begin
            match_cnt_d = sat_inc8(match_cnt_q);
        end
    end

    pat_match_1010 u_match (
        .clk   (clk),
        .rst   (rst),
        .clr   (accept),
        .en    (x_valid),
        .x     (x),
        .exp_z (exp_z)
    );

endmodule
